// File: rtl/img_pkg.sv
// Purpose: shared image geometry and load-sequencer state encoding for the image BRAM controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package img_pkg;

    localparam int WIDTH         = 320;
    localparam int HEIGHT        = 240;
    localparam int ADDR_W        = $clog2(WIDTH * HEIGHT);
    localparam int PIX_W         = 12;
    localparam int BYTES_PER_PIX = 2;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        COMMIT  = 2'd2,
        FULL    = 2'd3
    } load_state_t;

endpackage

// File: rtl/vga_read_addr_gen.sv
// Purpose: maps 640x480 scan coordinates onto 2x-upscaled BRAM read addresses, flags off-image pixels.
// Latency: rd_addr 1 cycle after vga_x/vga_y; show 2 cycles after vga_video_on (aligned with BRAM data).
// Backpressure: none; follows the VGA scan every cycle.
// Ports: clk_100MHz/rst_n (sync, active-low); en = display mode; vga_x/vga_y/vga_video_on in;
//        rd_addr = BRAM read address; show = pixel at BRAM output should be driven to the screen.
module vga_read_addr_gen
    import img_pkg::*;
#(
    parameter int WIDTH  = img_pkg::WIDTH,
    parameter int HEIGHT = img_pkg::HEIGHT,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk_100MHz,
    input  logic              rst_n,
    input  logic              en,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    input  logic              vga_video_on,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              show
);

    localparam logic [10:0] X_LIM = 11'(2 * WIDTH);
    localparam logic [10:0] Y_LIM = 11'(2 * HEIGHT);

    logic              blank;
    logic [ADDR_W-1:0] addr_nxt;
    logic              von_d1, von_d2;
    logic              blank_d1, blank_d2;

    assign blank    = ({1'b0, vga_x} >= X_LIM) || ({1'b0, vga_y} >= Y_LIM);
    assign addr_nxt = ADDR_W'(vga_y >> 1) * ADDR_W'(WIDTH) + ADDR_W'(vga_x >> 1);

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            rd_addr  <= '0;
            von_d1   <= 1'b0;
            von_d2   <= 1'b0;
            blank_d1 <= 1'b0;
            blank_d2 <= 1'b0;
        end else begin
            // Off-image coordinates keep the last address so the BRAM sees no spurious reads.
            if (en && !blank) begin
                rd_addr <= addr_nxt;
            end
            von_d1   <= vga_video_on;
            von_d2   <= von_d1;
            blank_d1 <= blank;
            blank_d2 <= blank_d1;
        end
    end

    assign show = von_d2 && !blank_d2;

endmodule

// File: rtl/image_mem_ctrl.sv
// Purpose: single-port image BRAM sequencer: UART byte pairs -> raster writes (load), VGA scan -> reads (display).
// Latency: load commits one cycle after the low byte; display returns RGB 3 cycles after the scan coordinate.
// Backpressure: none; rx bytes are accepted every cycle, bytes beyond a full image set the sticky overflow.
// Ports: clk_100MHz/rst_n (sync, active-low); display_sw raw switch; rx_data/rx_valid from UART;
//        vga_x/vga_y/vga_video_on from timing gen; mem_* to BRAM; vga_rgb to pins; load_done/overflow status.
module image_mem_ctrl
    import img_pkg::*;
#(
    parameter int WIDTH  = img_pkg::WIDTH,
    parameter int HEIGHT = img_pkg::HEIGHT,
    parameter int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk_100MHz,
    input  logic              rst_n,
    input  logic              display_sw,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic [9:0]        vga_x,
    input  logic [9:0]        vga_y,
    input  logic              vga_video_on,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_display,
    output logic [PIX_W-1:0]  mem_pixel_in,
    input  logic [PIX_W-1:0]  mem_pixel_out,
    output logic [PIX_W-1:0]  vga_rgb,
    output logic              load_done,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    logic              sw_meta, sw_sync;
    logic              enter_load, load_act;
    load_state_t       state, state_nxt;
    logic [3:0]        red;
    logic [PIX_W-1:0]  pix_q;
    logic [PIX_W-1:0]  rgb_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic              show;

    // Mode edges are acted on one cycle early (when sw_meta disagrees with sw_sync) so the
    // load-side reset lands on the same edge that flips mem_display.
    assign enter_load = sw_sync && !sw_meta;
    assign load_act   = !sw_sync && !sw_meta;

    vga_read_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_rd_gen (
        .clk_100MHz   (clk_100MHz),
        .rst_n        (rst_n),
        .en           (sw_sync),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_video_on (vga_video_on),
        .rd_addr      (rd_addr),
        .show         (show)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_HI: if (rx_valid) state_nxt = WAIT_LO;
            WAIT_LO: if (rx_valid) state_nxt = COMMIT;
            COMMIT: begin
                if (wr_ptr == LAST)  state_nxt = FULL;
                else if (rx_valid)   state_nxt = WAIT_LO;
                else                 state_nxt = WAIT_HI;
            end
            FULL:    state_nxt = FULL;
            default: state_nxt = WAIT_HI;
        endcase
        // Any partial pixel is dropped on a mode change or while displaying.
        if (!load_act) state_nxt = WAIT_HI;
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            sw_meta   <= 1'b0;
            sw_sync   <= 1'b0;
            state     <= WAIT_HI;
            red       <= '0;
            pix_q     <= '0;
            rgb_q     <= '0;
            wr_ptr    <= '0;
            load_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sw_meta <= display_sw;
            sw_sync <= sw_meta;
            state   <= state_nxt;
            rgb_q   <= (sw_meta && sw_sync && show) ? mem_pixel_out : '0;
            if (enter_load) begin
                wr_ptr    <= '0;
                load_done <= 1'b0;
                overflow  <= 1'b0;
            end else if (load_act) begin
                unique case (state)
                    WAIT_HI: if (rx_valid) red <= rx_data[3:0];
                    WAIT_LO: if (rx_valid) pix_q <= {red, rx_data};
                    COMMIT: begin
                        if (wr_ptr == LAST) begin
                            load_done <= 1'b1;
                            if (rx_valid) overflow <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                            // A byte landing in the commit cycle starts the next pixel.
                            if (rx_valid) red <= rx_data[3:0];
                        end
                    end
                    FULL:    if (rx_valid) overflow <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign mem_display  = sw_sync;
    assign mem_addr     = sw_sync ? rd_addr : wr_ptr;
    assign mem_pixel_in = pix_q;
    assign vga_rgb      = rgb_q;

endmodule

// File: tb/tb_image_mem_ctrl.sv
module tb_image_mem_ctrl;
    import img_pkg::*;

    localparam int W  = 320;
    localparam int H  = 16;
    localparam int N  = W * H;
    localparam int AW = $clog2(N);

    logic          clk_100MHz = 1'b0;
    logic          rst_n;
    logic          display_sw;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [9:0]    vga_x, vga_y;
    logic          vga_video_on;
    logic [AW-1:0] mem_addr;
    logic          mem_display;
    logic [11:0]   mem_pixel_in;
    logic [11:0]   mem_pixel_out;
    logic [11:0]   vga_rgb;
    logic          load_done, overflow;

    logic [11:0]   bram [0:N-1];

    int passed = 0;
    int total  = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    image_mem_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk_100MHz    (clk_100MHz),
        .rst_n         (rst_n),
        .display_sw    (display_sw),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_video_on  (vga_video_on),
        .mem_addr      (mem_addr),
        .mem_display   (mem_display),
        .mem_pixel_in  (mem_pixel_in),
        .mem_pixel_out (mem_pixel_out),
        .vga_rgb       (vga_rgb),
        .load_done     (load_done),
        .overflow      (overflow)
    );

    // Single-port BRAM: writes every cycle in load mode, 1-cycle registered read.
    always @(posedge clk_100MHz) begin
        if (!mem_display) bram[mem_addr] <= mem_pixel_in;
        mem_pixel_out <= bram[mem_addr];
    end

    task automatic tick;
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_disp"}, 32'(mem_display), 0);
        chk({tag, "_pix"},  32'(mem_pixel_in), 0);
        chk({tag, "_rgb"},  32'(vga_rgb), 0);
        chk({tag, "_done"}, 32'(load_done), 0);
        chk({tag, "_ovf"},  32'(overflow), 0);
    endtask

    initial begin
        int errs;
        for (int i = 0; i < N; i++) bram[i] = 12'h0;
        rst_n = 1'b0; display_sw = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        vga_x = 10'd0; vga_y = 10'd0; vga_video_on = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        chk("reset_state", 32'(dut.state), 32'(WAIT_HI));
        rst_n = 1'b1;
        tick();

        // First pixel: 0x0A, 0xBC -> 0xABC at address 0
        send(8'h0A);
        send(8'hBC);
        chk("t1_commit_state", 32'(dut.state), 32'(COMMIT));
        chk("t1_commit_pix",   32'(mem_pixel_in), 32'h0ABC);
        chk("t1_commit_addr",  32'(mem_addr), 0);
        tick();
        chk("t1_wrptr", 32'(mem_addr), 1);
        chk("t1_done",  32'(load_done), 0);
        chk("t1_bram0", 32'(bram[0]), 32'h0ABC);

        // Byte arriving in the commit cycle becomes the next high byte
        send(8'h0D);
        send(8'hEF);
        chk("t6_commit_addr", 32'(mem_addr), 1);
        send(8'h07);
        chk("t6_capture_state", 32'(dut.state), 32'(WAIT_LO));
        chk("t6_capture_addr",  32'(mem_addr), 2);
        send(8'h89);
        chk("t6_commit_pix",  32'(mem_pixel_in), 32'h0789);
        chk("t6_commit_addr", 32'(mem_addr), 2);
        tick();
        chk("t6_wrptr", 32'(mem_addr), 3);

        // Mid-pixel mode toggle discards the partial pixel and rewinds
        send(8'h0A);
        display_sw = 1'b1;
        repeat (3) tick();
        chk("t5_disp_on",    32'(mem_display), 1);
        chk("t5_disp_state", 32'(dut.state), 32'(WAIT_HI));
        display_sw = 1'b0;
        repeat (3) tick();
        chk("t5_load_on",    32'(mem_display), 0);
        chk("t5_load_addr",  32'(mem_addr), 0);
        chk("t5_load_state", 32'(dut.state), 32'(WAIT_HI));
        send(8'h01);
        send(8'h23);
        chk("t5_commit_pix",  32'(mem_pixel_in), 32'h0123);
        chk("t5_commit_addr", 32'(mem_addr), 0);
        tick();
        chk("t5_wrptr", 32'(mem_addr), 1);

        // Reset in the middle of a pixel
        send(8'h0A);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midrst");
        chk("midrst_state", 32'(dut.state), 32'(WAIT_HI));
        rst_n = 1'b1;
        tick();

        // Full image, pixel i = i[11:0], streamed back to back
        for (int i = 0; i < N; i++) begin
            send(8'((i >> 8) & 'hF));
            send(8'(i & 'hFF));
        end
        chk("t2_last_addr", 32'(mem_addr), 32'(N - 1));
        tick();
        chk("t2_full_state", 32'(dut.state), 32'(FULL));
        chk("t2_load_done",  32'(load_done), 1);
        chk("t2_ovf_before", 32'(overflow), 0);
        send(8'hFF);
        chk("t2_overflow",   32'(overflow), 1);
        chk("t2_addr_held",  32'(mem_addr), 32'(N - 1));

        display_sw = 1'b1;
        repeat (3) tick();
        chk("t2_disp_on",   32'(mem_display), 1);
        chk("t2_done_kept", 32'(load_done), 1);
        errs = 0;
        for (int i = 0; i < N; i++) if (bram[i] !== 12'(i)) errs++;
        chk("t2_bram_image", 32'(errs), 0);
        send(8'h55);
        chk("disp_rx_ignored", 32'(dut.state), 32'(WAIT_HI));

        // Display pipeline: in-image, blanked x, video off, last pixel, blanked y
        vga_x = 10'd5;   vga_y = 10'd3;  vga_video_on = 1'b1;
        tick();
        chk("t3_addr", 32'(mem_addr), 322);
        vga_x = 10'd640; vga_y = 10'd3;  vga_video_on = 1'b1;
        tick();
        chk("t4_addr_held_x", 32'(mem_addr), 322);
        vga_x = 10'd10;  vga_y = 10'd4;  vga_video_on = 1'b0;
        tick();
        chk("t3_rgb",      32'(vga_rgb), 32'h142);
        chk("t4_addr_off", 32'(mem_addr), 645);
        vga_x = 10'd639; vga_y = 10'(2 * H - 1); vga_video_on = 1'b1;
        tick();
        chk("t4_rgb_blank_x", 32'(vga_rgb), 0);
        chk("last_addr",      32'(mem_addr), 32'(N - 1));
        vga_x = 10'd0;   vga_y = 10'(2 * H); vga_video_on = 1'b1;
        tick();
        chk("t4_rgb_video_off", 32'(vga_rgb), 0);
        chk("t4_addr_held_y",   32'(mem_addr), 32'(N - 1));
        vga_video_on = 1'b0;
        tick();
        chk("last_rgb", 32'(vga_rgb), 32'h3FF);
        tick();
        chk("t4_rgb_blank_y", 32'(vga_rgb), 0);

        // Re-entering load mode clears status
        vga_x = 10'd5; vga_y = 10'd3; vga_video_on = 1'b1;
        display_sw = 1'b0;
        repeat (4) tick();
        chk("reload_disp", 32'(mem_display), 0);
        chk("reload_done", 32'(load_done), 0);
        chk("reload_ovf",  32'(overflow), 0);
        chk("reload_addr", 32'(mem_addr), 0);
        chk("reload_rgb",  32'(vga_rgb), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
